// File: rtl/packet_encoder_if.sv
// Handshake/bus bundle for packet_encoder: the host command fields, the UART tx
// done tick, and the byte stream / status outputs back to the transmitter and host.
interface packet_encoder_if #(
  parameter int unsigned DATA_BIT = 32
);
  logic                i_send;
  logic [DATA_BIT-1:0] i_output_pattern;
  logic [DATA_BIT-1:0] i_freq_pattern;
  logic                i_start;
  logic                i_stop;
  logic                i_mode;
  logic [3:0]          i_sel_out;
  logic                i_tx_done_tick;
  logic [7:0]          o_tx_data;
  logic                o_tx_start;
  logic                o_busy;
  logic                o_done_tick;
  logic                o_timeout;

  modport master (
    output i_send, i_output_pattern, i_freq_pattern, i_start, i_stop, i_mode,
           i_sel_out, i_tx_done_tick,
    input  o_tx_data, o_tx_start, o_busy, o_done_tick, o_timeout
  );

  modport slave (
    input  i_send, i_output_pattern, i_freq_pattern, i_start, i_stop, i_mode,
           i_sel_out, i_tx_done_tick,
    output o_tx_data, o_tx_start, o_busy, o_done_tick, o_timeout
  );
endinterface

// File: rtl/packet_encoder.sv
// Serialises one pattern command into the decoder's byte layout and feeds a UART tx
// one byte per start/done-tick handshake. Define PACKET_ENCODER_CHECKSUM_EN to append an XOR byte.
module packet_encoder #(
  parameter int unsigned DATA_BIT    = 32,
  parameter int unsigned PACK_NUM    = 9,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  packet_encoder_if.slave  bus
);
  localparam int unsigned BUF_W = 8 * PACK_NUM;
  localparam int unsigned CNT_W = $clog2(PACK_NUM + 1);
`ifdef PACKET_ENCODER_CHECKSUM_EN
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PACK_NUM);
  localparam logic [CNT_W-1:0] CSUM_IDX = CNT_W'(PACK_NUM - 1);
`else
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PACK_NUM - 1);
`endif
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYC);
  localparam bit          WD_EN  = (TIMEOUT_CYC != 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      timer_q, timer_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_start_q, tx_start_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             to_q, to_d;
`ifdef PACKET_ENCODER_CHECKSUM_EN
  logic [7:0]       csum_q, csum_d;
`endif

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    to_d    = 1'b0;
`ifdef PACKET_ENCODER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.i_send) begin
          buf_d   = {bus.i_sel_out, 1'b0, bus.i_mode, bus.i_stop, bus.i_start,
                     bus.i_freq_pattern, bus.i_output_pattern};
          cnt_d   = '0;
`ifdef PACKET_ENCODER_CHECKSUM_EN
          csum_d  = '0;
`endif
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A tick on the expiry cycle takes priority over the watchdog.
        if (bus.i_tx_done_tick) begin
          buf_d = buf_q >> 8;
          cnt_d = cnt_q + 1'b1;
`ifdef PACKET_ENCODER_CHECKSUM_EN
          csum_d = csum_q ^ buf_q[7:0];
          if (cnt_q == CSUM_IDX) buf_d[7:0] = csum_q ^ buf_q[7:0];
`endif
          state_d = (cnt_q == LAST_IDX) ? S_DONE : S_SEND;
        end else begin
          timer_d = timer_q + 16'd1;
          if (WD_EN && timer_d == TO_LIM) begin
            to_d    = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are derived from the next state.
    tx_start_d = (state_d == S_SEND);
    tx_data_d  = (state_d == S_SEND) ? buf_d[7:0] : tx_data_q;
    done_d     = (state_d == S_DONE);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      buf_q      <= '0;
      cnt_q      <= '0;
      timer_q    <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      to_q       <= 1'b0;
`ifdef PACKET_ENCODER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      timer_q    <= timer_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      to_q       <= to_d;
`ifdef PACKET_ENCODER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign bus.o_tx_data   = tx_data_q;
  assign bus.o_tx_start  = tx_start_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_done_tick = done_q;
  assign bus.o_timeout   = to_q;
endmodule

// File: tb/tb_packet_encoder.sv
// Scoreboard bench for packet_encoder: a byte-list reference model feeds queues that a
// negedge monitor drains; a UART tx model acks each byte after a programmable delay.
module tb_packet_encoder;
  localparam int unsigned DW = 32;
  localparam int unsigned PN = 9;
  localparam int unsigned TO = 16;
`ifdef PACKET_ENCODER_CHECKSUM_EN
  localparam int NB = PN + 1;
`else
  localparam int NB = PN;
`endif

  typedef struct packed {
    logic [31:0] out;
    logic [31:0] freq;
    logic        start;
    logic        stop;
    logic        mode;
    logic [3:0]  sel;
  } pkt_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  logic model_tick = 1'b0;
  logic spur_tick = 1'b0;

  logic [7:0] exp_q[$];
  pkt_t       pkt_q[$];
  int         exp_to = 0;
  int         send_cyc = 0;
  int         starts_total = 0;

  int ack_delay = 10;
  int special_idx = -1;
  int special_delay = 0;
  bit tick_on_start = 1'b0;

  packet_encoder_if #(.DATA_BIT(DW)) ifc ();
  assign ifc.i_tx_done_tick = model_tick | spur_tick;

  packet_encoder #(.DATA_BIT(DW), .PACK_NUM(PN), .TIMEOUT_CYC(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model: packet as a plain byte list built from the field layout.
  function automatic void push_exp(input pkt_t p, input int nb);
    int b[$];
    int x = 0;
    for (int k = 0; k < DW / 8; k++) b.push_back(int'((p.out >> (8 * k)) % 256));
    for (int k = 0; k < DW / 8; k++) b.push_back(int'((p.freq >> (8 * k)) % 256));
    b.push_back(p.sel * 16 + p.mode * 4 + p.stop * 2 + p.start);
`ifdef PACKET_ENCODER_CHECKSUM_EN
    foreach (b[i]) x = x ^ b[i];
    b.push_back(x);
`endif
    for (int i = 0; i < nb; i++) exp_q.push_back(8'(b[i]));
  endfunction

  function automatic pkt_t rand_pkt();
    pkt_t p;
    p.out   = $urandom;
    p.freq  = $urandom;
    p.start = 1'($urandom_range(0, 1));
    p.stop  = 1'($urandom_range(0, 1));
    p.mode  = 1'($urandom_range(0, 1));
    p.sel   = 4'($urandom_range(0, 15));
    return p;
  endfunction

  task automatic drive_fields(input pkt_t p);
    ifc.i_output_pattern = p.out;
    ifc.i_freq_pattern   = p.freq;
    ifc.i_start          = p.start;
    ifc.i_stop           = p.stop;
    ifc.i_mode           = p.mode;
    ifc.i_sel_out        = p.sel;
  endtask

  task automatic send_pkt(input pkt_t p, input int nb);
    @(negedge clk); #1;
    drive_fields(p);
    ifc.i_send = 1'b1;
    send_cyc = cyc;
    push_exp(p, nb);
    if (nb == NB) pkt_q.push_back(p);
    @(negedge clk); #1;
    ifc.i_send = 1'b0;
  endtask

  task automatic wait_sig(input int which, input int limit, input string name);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk); #1;
      if (which == 0 && ifc.o_done_tick) return;
      if (which == 1 && ifc.o_timeout) return;
    end
    chk({name, "_wait_expired"}, 1, 0);
  endtask

  task automatic wait_starts(input int target);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (starts_total >= target) return;
    end
    chk("start_wait_expired", starts_total, target);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_tx_data"}, ifc.o_tx_data, 0);
    chk({tag, "_tx_start"}, ifc.o_tx_start, 0);
    chk({tag, "_busy"}, ifc.o_busy, 0);
    chk({tag, "_done"}, ifc.o_done_tick, 0);
    chk({tag, "_timeout"}, ifc.o_timeout, 0);
  endtask

  // UART tx model: acks each started byte after a delay; delay 0 means never.
  initial begin
    int   cnt = 0;
    int   bidx = 0;
    bit   pend = 1'b0;
    int   d;
    logic [7:0] held = '0;
    forever begin
      @(posedge clk); #1;
      model_tick = 1'b0;
      if (!rst_n) begin
        pend = 1'b0;
        bidx = 0;
        continue;
      end
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          model_tick = 1'b1;
          pend = 1'b0;
          chk("tx_data_hold", ifc.o_tx_data, held);
        end
      end
      if (ifc.o_tx_start) begin
        held = ifc.o_tx_data;
        d = (bidx == special_idx) ? special_delay : ack_delay;
        if (d > 0) begin
          pend = 1'b1;
          cnt = d;
        end
        bidx++;
        if (tick_on_start) model_tick = 1'b1;
      end
      if (ifc.o_done_tick || ifc.o_timeout) bidx = 0;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a byte, done or timeout.
  initial begin
    logic [7:0] rx[$];
    int   last_tick_cyc = 0;
    int   last_start_cyc = 0;
    bit   chk_busy = 1'b0;
    pkt_t g, e;
    logic [7:0] c;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rx.delete();
        chk_busy = 1'b0;
        continue;
      end
      if (chk_busy) begin
        chk("busy_after_done", ifc.o_busy, 0);
        chk_busy = 1'b0;
      end
      if (ifc.o_tx_start) begin
        chk("start_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk($sformatf("byte%0d", rx.size()), ifc.o_tx_data, exp_q.pop_front());
        if (rx.size() == 0) chk("first_byte_latency", cyc, send_cyc + 1);
        else chk("inter_byte_gap", cyc, last_tick_cyc + 1);
        rx.push_back(ifc.o_tx_data);
        last_start_cyc = cyc;
        starts_total++;
      end
      if (ifc.i_tx_done_tick && !ifc.o_tx_start) last_tick_cyc = cyc;
      if (ifc.o_done_tick) begin
        chk("done_expected", pkt_q.size() > 0, 1);
        chk("bytes_left_at_done", exp_q.size(), 0);
        chk("done_latency", cyc, last_tick_cyc + 1);
        if (pkt_q.size() > 0 && rx.size() >= PN) begin
          e = pkt_q.pop_front();
          g = '0;
          for (int k = 0; k < 4; k++) g.out  = g.out  | (32'(rx[k])     << (8 * k));
          for (int k = 0; k < 4; k++) g.freq = g.freq | (32'(rx[4 + k]) << (8 * k));
          c = rx[8];
          g.start = 1'(c % 2);
          g.stop  = 1'((c / 2) % 2);
          g.mode  = 1'((c / 4) % 2);
          g.sel   = 4'(c / 16);
          chk("reserved_bit", (c / 8) % 2, 0);
          chk("decoded_fields", g, e);
        end else begin
          chk("rx_packet_length", rx.size(), NB);
        end
        rx.delete();
        chk_busy = 1'b1;
      end
      if (ifc.o_timeout) begin
        chk("timeout_expected", exp_to > 0, 1);
        if (exp_to > 0) exp_to--;
        chk("timeout_latency", cyc - last_start_cyc, TO + 1);
        chk("bytes_left_at_timeout", exp_q.size(), 0);
        chk("busy_at_timeout", ifc.o_busy, 0);
        rx.delete();
      end
    end
  end

  initial begin
    pkt_t p;
    int   base;
    ifc.i_send = 1'b0;
    drive_fields('0);
    repeat (3) @(negedge clk);
    #1;
    check_quiet("reset");
    rst_n = 1'b1;

    // Directed packet, acks 10 cycles after each start.
    p = '{out: 32'h12345678, freq: 32'h9ABCDEF0, start: 1'b1, stop: 1'b0, mode: 1'b1, sel: 4'd5};
    send_pkt(p, NB);
    wait_sig(0, 400, "directed_done");

    // Spurious ticks in idle and in the start cycle.
    @(negedge clk); #1; spur_tick = 1'b1;
    @(negedge clk); #1; spur_tick = 1'b0;
    tick_on_start = 1'b1;
    send_pkt(rand_pkt(), NB);
    wait_sig(0, 400, "spurious_done");
    tick_on_start = 1'b0;

    // Mid-packet send request with altered inputs, then a send as busy falls.
    base = starts_total;
    send_pkt(rand_pkt(), NB);
    wait_starts(base + 4);
    @(negedge clk); #1;
    drive_fields(rand_pkt());
    ifc.i_send = 1'b1;
    @(negedge clk); #1;
    ifc.i_send = 1'b0;
    wait_sig(0, 400, "busy_send_done");
    send_pkt(rand_pkt(), NB);
    wait_sig(0, 400, "back_to_back_done");

    // Watchdog: third byte never acked, then acked exactly on the expiry cycle.
    special_idx = 2;
    special_delay = 0;
    exp_to++;
    send_pkt(rand_pkt(), 3);
    wait_sig(1, 400, "timeout");
    repeat (30) @(negedge clk);
    special_delay = TO;
    send_pkt(rand_pkt(), NB);
    wait_sig(0, 600, "expiry_ack_done");
    special_idx = -1;

    // Reset while waiting on the third byte, then restart from byte 0x78.
    base = starts_total;
    send_pkt(p, NB);
    wait_starts(base + 3);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    pkt_q.delete();
    exp_to = 0;
    @(negedge clk); #1;
    check_quiet("midpkt_reset");
    rst_n = 1'b1;
    send_pkt(p, NB);
    wait_sig(0, 400, "after_reset_done");

    // Random loopback packets.
    for (int n = 0; n < 200; n++) begin
      ack_delay = $urandom_range(1, 12);
      tick_on_start = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk); #1; spur_tick = 1'b1;
        @(negedge clk); #1; spur_tick = 1'b0;
      end
      send_pkt(rand_pkt(), NB);
      wait_sig(0, 400, "random_done");
    end
    tick_on_start = 1'b0;
    repeat (20) @(negedge clk);
    chk("pending_bytes_at_end", exp_q.size(), 0);
    chk("pending_packets_at_end", pkt_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
